// File: rtl/mux_scan_controller.sv
// Scans an external 8-to-1 style mux channel by channel and captures its output into a registered word.
// The optional data_parity output is enabled with the MUX_SCAN_PARITY_EN macro.
module mux_scan_controller #(
  parameter int SEL_W  = 3,
  parameter int SETTLE = 0,
  localparam int N     = 1 << SEL_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic [SEL_W-1:0] Selector,
  input  logic             mux_out,
  output logic [N-1:0]     data,
  output logic             data_valid,
  input  logic             data_ready,
`ifdef MUX_SCAN_PARITY_EN
  output logic             data_parity,
`endif
  output logic [1:0]       fsm_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE > 0 ? SETTLE - 1 : 0);
  localparam logic [SEL_W-1:0] LAST_CH     = SEL_W'(N - 1);
  localparam state_t           FIRST_ST    = (SETTLE == 0) ? S_SAMPLE : S_SETTLE;

  state_t     state;
  logic [N-1:0] acc;
  logic [N-1:0] acc_next;
  logic [3:0]   cnt;

  assign busy      = (state != S_IDLE);
  assign fsm_state = state;

  // Accumulator with the current channel's sample merged in, so the last
  // channel can land in data on the same edge it is sampled.
  always_comb begin
    acc_next           = acc;
    acc_next[Selector] = mux_out;
  end

  // Handshake: data_valid rises on entry to HOLD and data/data_valid stay
  // frozen until a cycle with data_valid && data_ready; that cycle is the
  // transfer and data_valid is low on the following cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      Selector    <= '0;
      data        <= '0;
      data_valid  <= 1'b0;
      acc         <= '0;
      cnt         <= '0;
`ifdef MUX_SCAN_PARITY_EN
      data_parity <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          Selector <= '0;
          cnt      <= '0;
          if (start) begin
            acc   <= '0;
            state <= FIRST_ST;
          end
        end
        S_SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            cnt   <= '0;
            state <= S_SAMPLE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        S_SAMPLE: begin
          acc <= acc_next;
          cnt <= '0;
          if (Selector == LAST_CH) begin
            data        <= acc_next;
            data_valid  <= 1'b1;
            Selector    <= '0;
            state       <= S_HOLD;
`ifdef MUX_SCAN_PARITY_EN
            data_parity <= ^acc_next;
`endif
          end else begin
            Selector <= Selector + 1'b1;
            state    <= FIRST_ST;
          end
        end
        S_HOLD: begin
          if (data_ready) begin
            data_valid <= 1'b0;
            Selector   <= '0;
            cnt        <= '0;
            if (start) begin
              acc   <= '0;
              state <= FIRST_ST;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_controller.sv
// Directed bench for mux_scan_controller: one instance with SETTLE=0, one with SETTLE=2,
// each fed by a behavioural 8:1 mux. Define MUX_SCAN_PARITY_EN to also cover data_parity.
module tb_mux_scan_controller;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       start0 = 1'b0, start1 = 1'b0;
  logic       rdy0 = 1'b0, rdy1 = 1'b0;
  logic [7:0] mux_in0 = 8'h00, mux_in1 = 8'h00;

  logic [2:0] sel0, sel1;
  logic       busy0, busy1, dv0, dv1, mo0, mo1;
  logic [7:0] data0, data1;
  logic [1:0] st0, st1;
`ifdef MUX_SCAN_PARITY_EN
  logic       par0, par1;
`endif

  assign mo0 = mux_in0[sel0];
  assign mo1 = mux_in1[sel1];

  mux_scan_controller #(.SEL_W(3), .SETTLE(0)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .busy(busy0), .Selector(sel0),
    .mux_out(mo0), .data(data0), .data_valid(dv0), .data_ready(rdy0),
`ifdef MUX_SCAN_PARITY_EN
    .data_parity(par0),
`endif
    .fsm_state(st0)
  );

  mux_scan_controller #(.SEL_W(3), .SETTLE(2)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .busy(busy1), .Selector(sel1),
    .mux_out(mo1), .data(data1), .data_valid(dv1), .data_ready(rdy1),
`ifdef MUX_SCAN_PARITY_EN
    .data_parity(par1),
`endif
    .fsm_state(st1)
  );

  // scoreboard
  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: while a word is presented it must match the head of the queue;
  // the head is retired on the handshake cycle.
  always @(negedge clk) begin
    if (!reset && dv0) begin
      if (exp_q0.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL dut0_unexpected_valid: got data %0h expected no word", data0);
      end else begin
        check("dut0_data", data0, exp_q0[0]);
`ifdef MUX_SCAN_PARITY_EN
        check("dut0_parity", par0, ^exp_q0[0]);
`endif
        if (rdy0) void'(exp_q0.pop_front());
      end
    end
    if (!reset && dv1) begin
      if (exp_q1.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL dut1_unexpected_valid: got data %0h expected no word", data1);
      end else begin
        check("dut1_data", data1, exp_q1[0]);
`ifdef MUX_SCAN_PARITY_EN
        check("dut1_parity", par1, ^exp_q1[0]);
`endif
        if (rdy1) void'(exp_q1.pop_front());
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int which, input int budget);
    int n = 0;
    while (((which == 0) ? dv0 : dv1) !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check((which == 0) ? "dut0_valid_timeout" : "dut1_valid_timeout",
          (which == 0) ? dv0 : dv1, 1);
  endtask

  task automatic scan0(input logic [7:0] v);
    mux_in0 = v;
    exp_q0.push_back(v);
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    wait_valid(0, 20);
  endtask

  task automatic accept0();
    rdy0 = 1'b1;
    tick();
    rdy0 = 1'b0;
    check("dut0_valid_drop", dv0, 0);
    check("dut0_idle_after_accept", busy0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // reset state
    repeat (3) tick();
    check("rst_busy", busy0, 0);
    check("rst_sel", sel0, 0);
    check("rst_data", data0, 0);
    check("rst_valid", dv0, 0);
    check("rst_state", st0, 0);
    check("rst_busy1", busy1, 0);
`ifdef MUX_SCAN_PARITY_EN
    check("rst_parity", par0, 0);
`endif
    reset = 1'b0;
    tick();

    // Basic scan of A5 with exact timing; a stray start and data_ready mid-scan are ignored
    mux_in0 = 8'hA5;
    exp_q0.push_back(8'hA5);
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      check("scan_sel", sel0, c - 1);
      check("scan_busy", busy0, 1);
      check("scan_no_valid", dv0, 0);
      start0 = (c == 3);
      rdy0   = (c == 4);
      tick();
    end
    start0 = 1'b0;
    rdy0   = 1'b0;
    check("c9_valid", dv0, 1);
    check("c9_busy", busy0, 1);
    check("c9_sel", sel0, 0);

    // Back-pressure: inputs change while holding, word must not move
    mux_in0 = 8'h3C;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_valid", dv0, 1);
      check("hold_data", data0, 8'hA5);
    end
    accept0();

    // SETTLE=2 instance: three cycles per channel, valid at cycle 25
    mux_in1 = 8'h81;
    exp_q1.push_back(8'h81);
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      check("settle_sel", sel1, (c - 1) / 3);
      check("settle_no_valid", dv1, 0);
      tick();
    end
    check("c25_valid", dv1, 1);
    check("c25_data", data1, 8'h81);
    rdy1 = 1'b1;
    tick();
    rdy1 = 1'b0;
    check("dut1_valid_drop", dv1, 0);

    // Back-to-back: accept and restart in the same cycle
    scan0(8'h5A);
    mux_in0 = 8'hFF;
    exp_q0.push_back(8'hFF);
    rdy0   = 1'b1;
    start0 = 1'b1;
    tick();
    rdy0   = 1'b0;
    start0 = 1'b0;
    check("b2b_busy", busy0, 1);
    check("b2b_sel", sel0, 0);
    check("b2b_valid_drop", dv0, 0);
    repeat (7) tick();
    check("b2b_not_yet", dv0, 0);
    tick();
    check("b2b_valid", dv0, 1);
    check("b2b_data", data0, 8'hFF);
    accept0();

    // Reset while sampling channel 4 discards everything
    mux_in0 = 8'hC3;
    exp_q0.push_back(8'hC3);
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    repeat (4) tick();
    check("pre_rst_sel", sel0, 4);
    reset = 1'b1;
    exp_q0.delete();
    tick();
    check("abort_busy", busy0, 0);
    check("abort_sel", sel0, 0);
    check("abort_data", data0, 0);
    check("abort_valid", dv0, 0);
    reset = 1'b0;
    tick();
    scan0(8'h0F);
    check("after_abort_data", data0, 8'h0F);
    accept0();

`ifdef MUX_SCAN_PARITY_EN
    scan0(8'h07);
    check("parity_07", par0, 1);
    accept0();
    scan0(8'h03);
    check("parity_03", par0, 0);
    accept0();
    scan0(8'h07);
    accept0();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("parity_rst", par0, 0);
`endif

    tick();
    check("dut0_queue_empty", exp_q0.size(), 0);
    check("dut1_queue_empty", exp_q1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
